// File: rtl/sram_ecc_ctrl_1024x32.sv
// sram_ecc_ctrl_1024x32: request/response front end for a 1024 x 39 single-port
// SRAM macro. Each 32-bit word is stored with a (39,32) SECDED code when the
// macro SRAM_CTRL_ECC_EN is defined. Without it, the upper 7 bits are written
// as zero and ignored on read. Sub-word writes are done as read-modify-write.
//
// Handshake: a request transfers on a rising edge where req_valid_i && req_ready_o.
// A response transfers on a rising edge where rsp_valid_o && rsp_ready_i.
// A pending response holds all rsp_* outputs stable until it transfers.
//
// dbg_state_o exposes the controller state: 0 = IDLE, 1 = RD, 2 = RMW.
module sram_ecc_ctrl_1024x32 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [9:0]  req_addr_i,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_corr_o,
  output logic        rsp_err_o,
  output logic [15:0] corr_cnt_o,
  output logic        mem_req_o,
  output logic        mem_write_o,
  output logic        mem_wmask_o,
  output logic [9:0]  mem_addr_o,
  output logic [38:0] mem_wdata_o,
  input  logic [38:0] mem_rdata_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_RMW = 2'd2} state_t;

`ifdef SRAM_CTRL_ECC_EN
  // Hamming check bits: XOR of the positions of all set data bits. Data bits
  // fill the non-power-of-two positions 3..38 in ascending order.
  function automatic logic [5:0] f_check(input logic [31:0] d);
    logic [5:0] c;
    logic [5:0] p6;
    logic [4:0] di;
    c  = '0;
    di = '0;
    for (int pos = 1; pos < 39; pos++) begin
      p6 = pos[5:0];
      if ((p6 & (p6 - 6'd1)) != 6'd0) begin
        if (d[di]) c = c ^ p6;
        di = di + 5'd1;
      end
    end
    return c;
  endfunction

  function automatic logic [38:0] f_encode(input logic [31:0] d);
    logic [5:0] c;
    c = f_check(d);
    return {^{c, d}, c, d};
  endfunction

  // Returns {err, corr, corrected data}.
  function automatic logic [33:0] f_decode(input logic [38:0] w);
    logic [31:0] d;
    logic [5:0]  s;
    logic [5:0]  p6;
    logic [4:0]  di;
    logic        p;
    logic        corr;
    logic        err;
    d    = w[31:0];
    s    = f_check(d) ^ w[37:32];
    p    = ^w;
    corr = p && (s <= 6'd38);
    err  = (!p && (s != 6'd0)) || (p && (s > 6'd38));
    di   = '0;
    for (int pos = 1; pos < 39; pos++) begin
      p6 = pos[5:0];
      if ((p6 & (p6 - 6'd1)) != 6'd0) begin
        if (corr && (p6 == s)) d[di] = ~d[di];
        di = di + 5'd1;
      end
    end
    return {err, corr, d};
  endfunction
`else
  function automatic logic [38:0] f_encode(input logic [31:0] d);
    return {7'd0, d};
  endfunction

  // Check bits are not stored in this build, so they are never looked at.
  logic w_unused_ecc_bits;
  assign w_unused_ecc_bits = ^mem_rdata_i[38:32];
`endif

  state_t      r_state;
  logic [9:0]  r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_corr;
  logic        r_rsp_err;
  logic [15:0] r_corr_cnt;
  logic [9:0]  r_mem_addr;
  logic [38:0] r_mem_wdata;

  logic        w_accept;
  logic        w_partial;
  logic [31:0] w_dec_data;
  logic        w_dec_corr;
  logic        w_dec_err;
  logic [31:0] w_merged;
  logic        w_mem_req;
  logic        w_mem_write;
  logic        w_mem_wmask;
  logic [9:0]  w_mem_addr;
  logic [38:0] w_mem_wdata;

  assign req_ready_o = !rst_i && (r_state == S_IDLE) && (!r_rsp_valid || rsp_ready_i);
  assign w_accept    = req_valid_i && req_ready_o;
  assign w_partial   = (req_be_i != 4'h0) && (req_be_i != 4'hF);

  // Decode whatever the macro returns this cycle (meaningful in RD and RMW).
  always_comb begin
`ifdef SRAM_CTRL_ECC_EN
    {w_dec_err, w_dec_corr, w_dec_data} = f_decode(mem_rdata_i);
`else
    w_dec_err  = 1'b0;
    w_dec_corr = 1'b0;
    w_dec_data = mem_rdata_i[31:0];
`endif
  end

  // Enabled bytes come from the latched request, the rest from the old word.
  always_comb begin
    w_merged[7:0]   = r_be[0] ? r_wdata[7:0]   : w_dec_data[7:0];
    w_merged[15:8]  = r_be[1] ? r_wdata[15:8]  : w_dec_data[15:8];
    w_merged[23:16] = r_be[2] ? r_wdata[23:16] : w_dec_data[23:16];
    w_merged[31:24] = r_be[3] ? r_wdata[31:24] : w_dec_data[31:24];
  end

  // Macro controls: issued combinationally, address/data hold when not issuing.
  always_comb begin
    w_mem_req   = 1'b0;
    w_mem_write = 1'b0;
    w_mem_wmask = 1'b0;
    w_mem_addr  = r_mem_addr;
    w_mem_wdata = r_mem_wdata;
    if (!rst_i) begin
      if (r_state == S_IDLE && w_accept) begin
        if (!req_write_i || w_partial) begin
          w_mem_req  = 1'b1;
          w_mem_addr = req_addr_i;
        end else if (req_be_i == 4'hF) begin
          w_mem_req   = 1'b1;
          w_mem_write = 1'b1;
          w_mem_wmask = 1'b1;
          w_mem_addr  = req_addr_i;
          w_mem_wdata = f_encode(req_wdata_i);
        end
      end else if (r_state == S_RMW && !w_dec_err) begin
        w_mem_req   = 1'b1;
        w_mem_write = 1'b1;
        w_mem_wmask = 1'b1;
        w_mem_addr  = r_addr;
        w_mem_wdata = f_encode(w_merged);
      end
    end
  end

  assign mem_req_o   = w_mem_req;
  assign mem_write_o = w_mem_write;
  assign mem_wmask_o = w_mem_wmask;
  assign mem_addr_o  = w_mem_addr;
  assign mem_wdata_o = w_mem_wdata;

  // Controller FSM with response register, correction counter and held macro bus.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_corr  <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_corr_cnt  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_addr  <= w_mem_addr;
      r_mem_wdata <= w_mem_wdata;
      if (r_rsp_valid && rsp_ready_i) r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= req_addr_i;
            r_wdata <= req_wdata_i;
            r_be    <= req_be_i;
            if (!req_write_i) begin
              r_state <= S_RD;
            end else if (w_partial) begin
              r_state <= S_RMW;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= '0;
              r_rsp_corr  <= 1'b0;
              r_rsp_err   <= 1'b0;
            end
          end
        end
        S_RD: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= w_dec_data;
          r_rsp_corr  <= w_dec_corr;
          r_rsp_err   <= w_dec_err;
          r_state     <= S_IDLE;
        end
        S_RMW: begin
          r_rsp_valid <= 1'b1;
          r_rsp_rdata <= '0;
          r_rsp_corr  <= w_dec_corr;
          r_rsp_err   <= w_dec_err;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if ((r_state == S_RD || r_state == S_RMW) && w_dec_corr && (r_corr_cnt != 16'hFFFF))
        r_corr_cnt <= r_corr_cnt + 16'd1;
    end
  end

  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_corr_o  = r_rsp_corr;
  assign rsp_err_o   = r_rsp_err;
  assign corr_cnt_o  = r_corr_cnt;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_sram_ecc_ctrl_1024x32.sv
// Bench for sram_ecc_ctrl_1024x32: SRAM macro model, word-level reference model
// (data per address plus injected flip mask), directed scenarios and a random run.
module tb_sram_ecc_ctrl_1024x32;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  logic        req_valid_i, req_ready_o, req_write_i;
  logic [9:0]  req_addr_i;
  logic [3:0]  req_be_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_corr_o, rsp_err_o;
  logic [15:0] corr_cnt_o;
  logic        mem_req_o, mem_write_o, mem_wmask_o;
  logic [9:0]  mem_addr_o;
  logic [38:0] mem_wdata_o;
  logic [38:0] mem_rdata_i;
  logic [1:0]  dbg_state_o;

  sram_ecc_ctrl_1024x32 dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_addr_i(req_addr_i), .req_be_i(req_be_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_corr_o(rsp_corr_o), .rsp_err_o(rsp_err_o), .corr_cnt_o(corr_cnt_o),
    .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .mem_wmask_o(mem_wmask_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- SRAM macro model with backdoor ----------------
  logic [38:0] sram [1024];
  logic        bd_init, bd_wr;
  logic [9:0]  bd_addr;
  logic [38:0] bd_data;
  int          n_mem_rd = 0;
  int          n_mem_wr = 0;

  function automatic logic [38:0] ref_encode(input logic [31:0] d);
`ifdef SRAM_CTRL_ECC_EN
    int pos_of [32];
    int j;
    logic [5:0] c;
    j = 0;
    for (int p = 1; p <= 38; p++)
      if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16 && p != 32) begin
        pos_of[j] = p;
        j++;
      end
    c = '0;
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < 32; i++)
        if (((pos_of[i] >> k) & 1) == 1) c[k] = c[k] ^ d[i];
    return {^{c, d}, c, d};
`else
    return {7'd0, d};
`endif
  endfunction

  always @(posedge clk_i) begin
    if (bd_init) begin
      for (int i = 0; i < 1024; i++) sram[i] <= ref_encode(32'h0);
    end else if (bd_wr) begin
      sram[bd_addr] <= bd_data;
    end
    if (mem_req_o && mem_write_o && mem_wmask_o) begin
      sram[mem_addr_o] <= mem_wdata_o;
      n_mem_wr <= n_mem_wr + 1;
    end
    if (mem_req_o && !mem_write_o) begin
      mem_rdata_i <= sram[mem_addr_o];
      n_mem_rd <= n_mem_rd + 1;
    end
  end

  // ---------------- reference model and scoreboard ----------------
  logic [31:0] m_data [1024];
  logic [38:0] m_flip [1024];
  int          m_cnt;
  // {rdata_dont_care, err, corr, rdata}
  logic [34:0] exp_q [$];
  int          n_cmp = 0;
  int          n_mis = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_accept(input logic w, input logic [9:0] a, input logic [3:0] be,
                              input logic [31:0] d);
    logic [31:0] old, bm;
    logic c, e;
    int nf;
    nf = $countones(m_flip[a]);
`ifdef SRAM_CTRL_ECC_EN
    old = m_data[a];
    c = (nf == 1);
    e = (nf == 2);
`else
    old = m_data[a] ^ m_flip[a][31:0];
    c = 1'b0;
    e = 1'b0;
`endif
    if (!w) begin
      exp_q.push_back({e, e, c, old});
      if (c && m_cnt < 65535) m_cnt++;
    end else if (be == 4'h0) begin
      exp_q.push_back(35'd0);
    end else if (be == 4'hF) begin
      exp_q.push_back(35'd0);
      m_data[a] = d;
      m_flip[a] = '0;
    end else begin
      exp_q.push_back({1'b0, e, c, 32'd0});
      if (c && m_cnt < 65535) m_cnt++;
      if (!e) begin
        bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        m_data[a] = (d & bm) | (old & ~bm);
        m_flip[a] = '0;
      end
    end
  endtask

  task automatic check_rsp(input string tag);
    logic [34:0] e;
    if (exp_q.size() == 0) begin
      check_val({tag, "_unexpected_rsp"}, 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    if (!e[34]) check_val({tag, "_rdata"}, 64'(rsp_rdata_o), 64'(e[31:0]));
    check_val({tag, "_corr"}, 64'(rsp_corr_o), 64'(e[32]));
    check_val({tag, "_err"}, 64'(rsp_err_o), 64'(e[33]));
  endtask

  task automatic check_store(input string tag, input logic [9:0] a);
    check_val(tag, 64'(sram[a]), 64'(ref_encode(m_data[a]) ^ m_flip[a]));
  endtask

  task automatic inject(input logic [9:0] a, input logic [38:0] mask);
    @(negedge clk_i);
    bd_wr = 1'b1; bd_addr = a; bd_data = sram[a] ^ mask;
    @(posedge clk_i);
    #1 bd_wr = 1'b0;
    m_flip[a] = m_flip[a] ^ mask;
  endtask

  // ---------------- driver: one request with checks ----------------
  task automatic xact(input logic w, input logic [9:0] a, input logic [3:0] be,
                      input logic [31:0] d, input string tag, output logic [31:0] rd);
    int n, lat, rd0, wr0, exp_lat, exp_rd, exp_wr;
    logic partial;
    logic [34:0] e;
    partial = w && be != 4'h0 && be != 4'hF;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_write_i = w; req_addr_i = a; req_be_i = be; req_wdata_i = d;
    rsp_ready_i = 1'b1;
    #1 n = 0;
    while (!req_ready_o && n < 20) begin @(negedge clk_i); #1 n++; end
    check_val({tag, "_ready"}, 64'(req_ready_o), 64'd1);
    if (!w || partial) begin
      check_val({tag, "_t_req"}, 64'(mem_req_o), 64'd1);
      check_val({tag, "_t_wr"}, 64'(mem_write_o), 64'd0);
      check_val({tag, "_t_addr"}, 64'(mem_addr_o), 64'(a));
    end else if (be == 4'hF) begin
      check_val({tag, "_t_req"}, 64'({mem_req_o, mem_write_o, mem_wmask_o}), 64'd7);
      check_val({tag, "_t_addr"}, 64'(mem_addr_o), 64'(a));
      check_val({tag, "_t_wdata"}, 64'(mem_wdata_o), 64'(ref_encode(d)));
    end else begin
      check_val({tag, "_t_req"}, 64'(mem_req_o), 64'd0);
    end
    rd0 = n_mem_rd;
    wr0 = n_mem_wr;
    model_accept(w, a, be, d);
    e = exp_q[exp_q.size() - 1];
    exp_lat = (!w || partial) ? 2 : 1;
    exp_rd  = (!w || partial) ? 1 : 0;
    exp_wr  = ((w && be == 4'hF) || (partial && !e[33])) ? 1 : 0;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    #1 lat = 1;
    while (!rsp_valid_o && lat < 8) begin @(negedge clk_i); #1 lat++; end
    check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    rd = rsp_rdata_o;
    check_rsp(tag);
    check_val({tag, "_mem_rd"}, 64'(n_mem_rd - rd0), 64'(exp_rd));
    check_val({tag, "_mem_wr"}, 64'(n_mem_wr - wr0), 64'(exp_wr));
    check_val({tag, "_cnt"}, 64'(corr_cnt_o), 64'(m_cnt));
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd;
    logic [31:0] bp_data;
    int wr0;
    logic pend, pw, stalled;
    logic [9:0] pa;
    logic [3:0] pb;
    logic [31:0] pd;
    logic [33:0] hold;

    rst_i = 1'b1; bd_init = 1'b1; bd_wr = 1'b0; bd_addr = '0; bd_data = '0;
    req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0; req_be_i = '0; req_wdata_i = '0;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 1024; i++) begin m_data[i] = '0; m_flip[i] = '0; end
    m_cnt = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    bd_init = 1'b0;
    req_valid_i = 1'b1; rsp_ready_i = 1'b1;
    #1;
    check_val("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check_val("rst_rsp_rdata", 64'(rsp_rdata_o), 64'd0);
    check_val("rst_rsp_flags", 64'({rsp_corr_o, rsp_err_o}), 64'd0);
    check_val("rst_cnt", 64'(corr_cnt_o), 64'd0);
    check_val("rst_mem_ctl", 64'({mem_req_o, mem_write_o, mem_wmask_o}), 64'd0);
    check_val("rst_req_ready", 64'(req_ready_o), 64'd0);
    check_val("rst_state", 64'(dbg_state_o), 64'd0);
    @(negedge clk_i);
    req_valid_i = 1'b0; rst_i = 1'b0;

    // full write then read
    xact(1'b1, 10'h155, 4'hF, 32'hDEADBEEF, "fw", rd);
    check_store("fw_store", 10'h155);
    xact(1'b0, 10'h155, 4'h0, 32'h0, "fw_rd", rd);
    check_val("fw_rd_const", 64'(rd), 64'hDEADBEEF);

    // partial write (read-modify-write)
    xact(1'b1, 10'd3, 4'hF, 32'h12345678, "pw_init", rd);
    xact(1'b1, 10'd3, 4'b0101, 32'hAABBCCDD, "pw", rd);
    check_store("pw_store", 10'd3);
    xact(1'b0, 10'd3, 4'h0, 32'h0, "pw_rd", rd);
    check_val("pw_rd_const", 64'(rd), 64'h12BB56DD);

    // be=0000 write: ack only
    xact(1'b1, 10'd3, 4'h0, 32'hFFFFFFFF, "be0", rd);
    check_store("be0_store", 10'd3);

    // single-bit error on addr 9
    xact(1'b1, 10'd9, 4'hF, 32'h0F0F0F0F, "sb_init", rd);
    inject(10'd9, 39'h80);
    xact(1'b0, 10'd9, 4'h0, 32'h0, "sb_rd", rd);

    // double-bit error on addr 9, partial write must not write back
    xact(1'b1, 10'd9, 4'hF, 32'h0F0F0F0F, "db_init", rd);
    inject(10'd9, 39'h3);
    xact(1'b1, 10'd9, 4'b0001, 32'h00000055, "db_pw", rd);
    check_store("db_store", 10'd9);

    // backpressure: read with response held for 5 cycles, write queued behind it
    @(negedge clk_i);
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 10'h155; req_be_i = 4'h0;
    rsp_ready_i = 1'b0;
    #1 check_val("bp_accept", 64'(req_ready_o), 64'd1);
    model_accept(1'b0, 10'h155, 4'h0, 32'h0);
    bp_data = $urandom;
    @(negedge clk_i);
    req_write_i = 1'b1; req_addr_i = 10'h20; req_be_i = 4'hF; req_wdata_i = bp_data;
    #1 check_val("bp_ready_rd", 64'(req_ready_o), 64'd0);
    @(negedge clk_i);
    #1;
    for (int i = 0; i < 5; i++) begin
      check_val("bp_hold_valid", 64'(rsp_valid_o), 64'd1);
      check_val("bp_hold_rdata", 64'(rsp_rdata_o), 64'(exp_q[0][31:0]));
      check_val("bp_hold_ready", 64'(req_ready_o), 64'd0);
      @(negedge clk_i);
      #1;
    end
    rsp_ready_i = 1'b1;
    #1 check_val("bp_release_ready", 64'(req_ready_o), 64'd1);
    check_rsp("bp_rd");
    model_accept(1'b1, 10'h20, 4'hF, bp_data);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    #1 check_val("bp_wr_valid", 64'(rsp_valid_o), 64'd1);
    check_rsp("bp_wr");
    #10 check_store("bp_store", 10'h20);

    // reset during the RMW cycle
    xact(1'b1, 10'h40, 4'hF, 32'hCAFEF00D, "rr_init", rd);
    @(negedge clk_i);
    req_valid_i = 1'b1; req_write_i = 1'b1; req_addr_i = 10'h40; req_be_i = 4'b0011;
    req_wdata_i = 32'h11112222;
    #1 check_val("rr_accept", 64'(req_ready_o), 64'd1);
    wr0 = n_mem_wr;
    @(negedge clk_i);
    req_valid_i = 1'b0; rst_i = 1'b1;
    #1 check_val("rr_in_rmw", 64'(dbg_state_o), 64'd2);
    check_val("rr_no_memreq", 64'(mem_req_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    m_cnt = 0;
    #1;
    check_val("rr_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check_val("rr_state", 64'(dbg_state_o), 64'd0);
    check_val("rr_no_write", 64'(n_mem_wr - wr0), 64'd0);
    check_store("rr_store", 10'h40);
    xact(1'b0, 10'h40, 4'h0, 32'h0, "rr_rd", rd);

    // randomized traffic with random response backpressure
    pend = 1'b0; stalled = 1'b0; hold = '0;
    pw = 1'b0; pa = '0; pb = '0; pd = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        pw = 1'($urandom_range(0, 1));
        pa = 10'($urandom_range(0, 15));
        pb = 4'($urandom_range(0, 15));
        pd = $urandom;
      end
      req_valid_i = pend; req_write_i = pw; req_addr_i = pa; req_be_i = pb; req_wdata_i = pd;
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      if (stalled) begin
        check_val("rnd_hold_valid", 64'(rsp_valid_o), 64'd1);
        check_val("rnd_hold_rsp", 64'({rsp_err_o, rsp_corr_o, rsp_rdata_o}), 64'(hold));
      end
      stalled = rsp_valid_o && !rsp_ready_i;
      hold = {rsp_err_o, rsp_corr_o, rsp_rdata_o};
      if (rsp_valid_o && rsp_ready_i) check_rsp("rnd");
      if (req_valid_i && req_ready_o) begin
        model_accept(pw, pa, pb, pd);
        pend = 1'b0;
      end
    end
    @(negedge clk_i);
    req_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rsp_ready_i = 1'b1;
      #1 if (rsp_valid_o) check_rsp("drain");
      @(negedge clk_i);
    end
    #1;
    check_val("end_queue_empty", 64'(exp_q.size()), 64'd0);
    check_val("end_cnt", 64'(corr_cnt_o), 64'(m_cnt));
    for (int a = 0; a < 16; a++) check_store("end_store", 10'(a));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
